// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
// Channel FSM state encoding and synchronizer depth.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int DB_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer feeding a tick-qualified
// four-state FSM with registered level and single-cycle edge pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int QW = (STABLE_TICKS < 1) ? 1 : $clog2(STABLE_TICKS + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(STABLE_TICKS - 1);

  logic [DB_SYNC_STAGES-1:0] sync_q;
  logic                      s_in;

  db_state_t       state, state_nxt;
  logic [QW-1:0]   q_cnt, q_nxt;
  logic            level_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[DB_SYNC_STAGES-2:0], raw};
  end

  assign s_in = sync_q[DB_SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ZERO;
      q_cnt <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      q_cnt <= q_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // A reversal of s_in in a WAIT state takes priority over a coincident tick.
  always_comb begin
    state_nxt = state;
    q_nxt     = q_cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ZERO: begin
        level_nxt = 1'b0;
        if (s_in) begin
          state_nxt = WAIT1;
          q_nxt     = '0;
        end
      end
      WAIT1: begin
        if (!s_in) begin
          state_nxt = ZERO;
        end else if (tick) begin
          if (q_cnt == Q_LAST) begin
            state_nxt = ONE;
            level_nxt = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            q_nxt = q_cnt + 1'b1;
          end
        end
      end
      ONE: begin
        level_nxt = 1'b1;
        if (!s_in) begin
          state_nxt = WAIT0;
          q_nxt     = '0;
        end
      end
      WAIT0: begin
        if (s_in) begin
          state_nxt = ONE;
        end else if (tick) begin
          if (q_cnt == Q_LAST) begin
            state_nxt = ZERO;
            level_nxt = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            q_nxt = q_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ZERO;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dual_input_debouncer.sv
// Multi-channel switch debouncer: one shared sample-tick divider and
// an array of independent debounce channels.
module dual_input_debouncer
  import debounce_pkg::*;
#(
  parameter int N_IN         = 2,
  parameter int TICK_DIV     = 1_000_000,
  parameter int STABLE_TICKS = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] db_level,
  output logic [N_IN-1:0] db_rise,
  output logic [N_IN-1:0] db_fall
);

  localparam int DW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .raw    (raw_in[g]),
      .level  (db_level[g]),
      .rise   (db_rise[g]),
      .fall   (db_fall[g])
    );
  end

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Randomized and directed checks of dual_input_debouncer against a
// tick-counting reference model.
module tb_dual_input_debouncer;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] db_level, db_rise, db_fall;

  int n_checks = 0;
  int n_fail   = 0;

  dual_input_debouncer #(.N_IN(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_in  (raw_in),
    .db_level(db_level),
    .db_rise (db_rise),
    .db_fall (db_fall)
  );

  always #5 clk = ~clk;

  // Reference model. Edges since reset release are numbered from 1; a tick
  // lands on every edge that is a multiple of TD. A pending change commits
  // once ST ticks have occurred strictly after the edge where the
  // synchronized input first disagreed with the level.
  logic [N-1:0] h1, h2;
  int unsigned  edge_no;
  logic [N-1:0] m_lvl, m_pend, m_rise, m_fall;
  int unsigned  m_since [N];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1 <= '0; h2 <= '0; edge_no <= 0;
      m_lvl <= '0; m_pend <= '0; m_rise <= '0; m_fall <= '0;
      for (int i = 0; i < N; i++) m_since[i] <= 0;
    end else begin
      automatic int unsigned en = edge_no + 1;
      automatic logic [N-1:0] lv = m_lvl;
      automatic logic [N-1:0] pd = m_pend;
      automatic logic [N-1:0] r  = '0;
      automatic logic [N-1:0] f  = '0;
      for (int ch = 0; ch < N; ch++) begin
        if (h2[ch] == lv[ch]) begin
          pd[ch] = 1'b0;
        end else if (!pd[ch]) begin
          pd[ch] = 1'b1;
          m_since[ch] <= en;
        end else if ((en % TD) == 0 && (en / TD - m_since[ch] / TD) >= ST) begin
          if (lv[ch]) f[ch] = 1'b1; else r[ch] = 1'b1;
          lv[ch] = ~lv[ch];
          pd[ch] = 1'b0;
        end
      end
      h1 <= raw_in; h2 <= h1; edge_no <= en;
      m_lvl <= lv; m_pend <= pd; m_rise <= r; m_fall <= f;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    raw_in  = 2'b11;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (db_level !== 2'b00 || db_rise !== 2'b00 || db_fall !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_hold: level=%b rise=%b fall=%b want 00/00/00", db_level, db_rise, db_fall);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (db_level !== 2'b00 || db_rise !== 2'b00 || db_fall !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: level=%b rise=%b fall=%b want 00/00/00", db_level, db_rise, db_fall);
    end
    raw_in  = 2'b00;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_rise();
    int lat = 0, rises = 0;
    raw_in[0] = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      n_checks++;
      if (db_level !== m_lvl || db_rise !== m_rise || db_fall !== m_fall) begin
        n_fail++;
        $display("FAIL rise_model c%0d: level=%b rise=%b fall=%b want %b/%b/%b", n, db_level, db_rise, db_fall, m_lvl, m_rise, m_fall);
      end
      if (db_level[0] && lat == 0) lat = n;
      if (db_rise[0]) rises++;
    end
    n_checks++;
    if (lat < 11 || lat > 15) begin
      n_fail++;
      $display("FAIL rise_latency: got %0d cycles want 11..15", lat);
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL rise_pulse_count: got %0d want 1", rises);
    end
  endtask

  task automatic test_glitch();
    int rises = 0;
    raw_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    raw_in[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (db_rise[0]) rises++;
    end
    raw_in[0] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (db_rise[0]) rises++;
      n_checks++;
      if (db_level[0] !== 1'b0 || db_level !== m_lvl) begin
        n_fail++;
        $display("FAIL glitch_level c%0d: level=%b want bit0=0 model=%b", n, db_level, m_lvl);
      end
    end
    n_checks++;
    if (rises != 0) begin
      n_fail++;
      $display("FAIL glitch_rise: got %0d pulses want 0", rises);
    end
  endtask

  task automatic test_fall();
    int lat = 0, falls = 0;
    raw_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (db_level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_setup: level0=%b want 1", db_level[0]);
    end
    raw_in[0] = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      n_checks++;
      if (db_level !== m_lvl || db_rise !== m_rise || db_fall !== m_fall) begin
        n_fail++;
        $display("FAIL fall_model c%0d: level=%b rise=%b fall=%b want %b/%b/%b", n, db_level, db_rise, db_fall, m_lvl, m_rise, m_fall);
      end
      if (!db_level[0] && lat == 0) lat = n;
      if (db_fall[0]) falls++;
    end
    n_checks++;
    if (lat < 11 || lat > 15) begin
      n_fail++;
      $display("FAIL fall_latency: got %0d cycles want 11..15", lat);
    end
    n_checks++;
    if (falls != 1) begin
      n_fail++;
      $display("FAIL fall_pulse_count: got %0d want 1", falls);
    end
  endtask

  task automatic test_simultaneous();
    int both = 0, single = 0;
    raw_in = 2'b11;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (db_rise == 2'b11) both++;
      if (db_rise == 2'b01 || db_rise == 2'b10) single++;
      n_checks++;
      if (db_level == 2'b01 || db_level == 2'b10) begin
        n_fail++;
        $display("FAIL simul_level c%0d: level=%b want 00 or 11", n, db_level);
      end
    end
    n_checks++;
    if (both != 1 || single != 0 || db_level !== 2'b11) begin
      n_fail++;
      $display("FAIL simul_rise: joint=%0d split=%0d level=%b want 1/0/11", both, single, db_level);
    end
    raw_in = 2'b00;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat = 0, rises = 0;
    raw_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (db_level[0] !== 1'b0 || db_rise[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_hold: level0=%b rise0=%b want 0/0", db_level[0], db_rise[0]);
      end
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (db_level[0] && lat == 0) lat = n;
      if (db_rise[0]) rises++;
    end
    n_checks++;
    if (lat < 11 || lat > 15 || rises != 1) begin
      n_fail++;
      $display("FAIL midreset_redebounce: latency=%0d rises=%0d want 11..15/1", lat, rises);
    end
    raw_in = 2'b00;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 80; seg++) begin
      raw_in = N'($urandom);
      repeat ($urandom_range(1, 20)) begin
        @(negedge clk);
        n_checks++;
        if (db_level !== m_lvl || db_rise !== m_rise || db_fall !== m_fall) begin
          n_fail++;
          $display("FAIL random s%0d: level=%b rise=%b fall=%b want %b/%b/%b", seg, db_level, db_rise, db_fall, m_lvl, m_rise, m_fall);
        end
        n_checks++;
        if ((db_rise & db_fall) !== '0) begin
          n_fail++;
          $display("FAIL random_pulse_excl s%0d: rise=%b fall=%b want disjoint", seg, db_rise, db_fall);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
